// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver. The serial line is LSB first and idles high. The line
//   is resynchronised into the clk domain. Each frame is sampled once per bit,
//   at the bit centre, with the centres measured from the detected start edge.
//
// Parameters
//   CLKS_PER_BIT        clk cycles per serial bit (4..65535)
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   UART_Rx             serial input line (asynchronous to clk)
//   UART_Rx_Data        last correctly framed byte (registered)
//   UART_Rx_Data_Ready  one-cycle strobe: UART_Rx_Data holds a new byte
//   UART_Rx_Frame_Err   one-cycle strobe: stop bit was sampled low
//   UART_Rx_Busy        high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       UART_Rx,
    output logic [7:0] UART_Rx_Data,
    output logic       UART_Rx_Data_Ready,
    output logic       UART_Rx_Frame_Err,
    output logic       UART_Rx_Busy
);

    localparam int          HALF      = CLKS_PER_BIT / 2;
    // The counter restarts at 0 on the edge after each event. The sample edge
    // is therefore the edge on which the counter already holds (interval - 1).
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shift;
    logic        rx_meta;
    logic        rx_s;

    // Two-flop synchronizer. Both flops reset to the idle level, so a reset
    // alone never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_Rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            idx                <= '0;
            shift              <= '0;
            UART_Rx_Data       <= '0;
            UART_Rx_Data_Ready <= 1'b0;
            UART_Rx_Frame_Err  <= 1'b0;
        end else begin
            UART_Rx_Data_Ready <= 1'b0;
            UART_Rx_Frame_Err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        // A start bit that is high again at its centre was a
                        // glitch. Drop it silently.
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        // LSB arrives first. Shifting right from the top
                        // leaves bit 0 in position 0 after eight samples.
                        shift <= {rx_s, shift[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            UART_Rx_Data       <= shift;
                            UART_Rx_Data_Ready <= 1'b1;
                            state              <= IDLE;
                        end else begin
                            UART_Rx_Frame_Err <= 1'b1;
                            state             <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BREAK: begin
                    // Wait out a held-low line so that it produces one error
                    // rather than a stream of zero frames.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign UART_Rx_Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx with CLKS_PER_BIT = 16. The line is driven on
//   the falling clock edge. A monitor records every Ready/Frame_Err strobe
//   together with the cycle in which it appeared. The main sequence compares
//   those records against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       ready;
    logic       ferr;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fall_cyc;
    int ferr_cnt = 0;
    int viol_cnt = 0;
    logic prev_ready = 1'b0;
    logic prev_ferr  = 1'b0;
    logic [7:0] rdy_q[$];
    int         rdy_cyc_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .UART_Rx            (rx),
        .UART_Rx_Data       (data),
        .UART_Rx_Data_Ready (ready),
        .UART_Rx_Frame_Err  (ferr),
        .UART_Rx_Busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Strobe recorder, sampled away from the active edge.
    always @(negedge clk) begin
        if (ready) begin
            rdy_q.push_back(data);
            rdy_cyc_q.push_back(cyc);
        end
        if (ferr) ferr_cnt = ferr_cnt + 1;
        if ((ready && ferr) || (ready && prev_ready) || (ferr && prev_ferr))
            viol_cnt = viol_cnt + 1;
        prev_ready = ready;
        prev_ferr  = ferr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Must be entered at a falling edge. It returns at a falling edge, so
    // consecutive calls give back-to-back frames with no gap.
    task automatic drive_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
        rx = 1'b0;
        fall_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_v;
        repeat (stop_len) @(negedge clk);
    endtask

    initial begin
        int n0;
        int f0;
        logic [7:0] hold;

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data",  {24'd0, data}, 32'h00);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_ferr",  {31'd0, ferr}, 32'd0);
        check("reset_busy",  {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single good frame 0xA5.
        n0 = rdy_q.size();
        f0 = ferr_cnt;
        drive_frame(8'hA5, 1'b1, CPB);
        repeat (4) @(negedge clk);
        check("a5_ready_count", rdy_q.size() - n0, 1);
        check("a5_data", {24'd0, (rdy_q.size() > n0) ? rdy_q[n0] : 8'hxx}, 32'hA5);
        check("a5_latency_ok",
              (rdy_q.size() > n0 && rdy_cyc_q[n0] - fall_cyc >= 154 && rdy_cyc_q[n0] - fall_cyc <= 156) ? 1 : 0, 1);
        check("a5_no_ferr", ferr_cnt - f0, 0);
        check("a5_data_port", {24'd0, data}, 32'hA5);

        // Back-to-back 0x00 then 0xFF.
        n0 = rdy_q.size();
        drive_frame(8'h00, 1'b1, CPB);
        drive_frame(8'hFF, 1'b1, CPB);
        repeat (4) @(negedge clk);
        check("b2b_ready_count", rdy_q.size() - n0, 2);
        check("b2b_first",  {24'd0, (rdy_q.size() > n0) ? rdy_q[n0] : 8'hxx}, 32'h00);
        check("b2b_second", {24'd0, (rdy_q.size() > n0 + 1) ? rdy_q[n0 + 1] : 8'hxx}, 32'hFF);
        check("b2b_spacing", (rdy_q.size() > n0 + 1) ? rdy_cyc_q[n0 + 1] - rdy_cyc_q[n0] : -1, 160);

        // False start: 4-cycle low pulse.
        n0 = rdy_q.size();
        f0 = ferr_cnt;
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        repeat (12) @(negedge clk);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        check("glitch_no_ready", rdy_q.size() - n0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_data_hold", {24'd0, data}, 32'hFF);

        // Framing error (0x3C, stop low, line held low), then 0x81.
        n0 = rdy_q.size();
        f0 = ferr_cnt;
        drive_frame(8'h3C, 1'b0, 40);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        check("ferr_once", ferr_cnt - f0, 1);
        check("ferr_no_ready", rdy_q.size() - n0, 0);
        check("ferr_data_hold", {24'd0, data}, 32'hFF);
        drive_frame(8'h81, 1'b1, CPB);
        repeat (4) @(negedge clk);
        check("after_ferr_ready", rdy_q.size() - n0, 1);
        check("after_ferr_data", {24'd0, (rdy_q.size() > n0) ? rdy_q[n0] : 8'hxx}, 32'h81);

        // Reset during bit 4 of a frame carrying 0x0F.
        hold = 8'h0F;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = hold[i];
            repeat (CPB) @(negedge clk);
        end
        rx = hold[4];
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("midrst_data",  {24'd0, data}, 32'h00);
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_ferr",  {31'd0, ferr}, 32'd0);
        check("midrst_busy",  {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 5; i < 8; i++) begin
            rx = hold[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (200) @(negedge clk);
        n0 = rdy_q.size();
        drive_frame(8'h5A, 1'b1, CPB);
        repeat (4) @(negedge clk);
        check("after_rst_data", {24'd0, (rdy_q.size() > n0) ? rdy_q[n0] : 8'hxx}, 32'h5A);
        check("after_rst_port", {24'd0, data}, 32'h5A);

        check("strobe_rules", viol_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud), giving clk cycles per serial bit; legal range 4..65535.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 UART_Rx  input  1  serial line, asynchronous to clk; idles high; 8N1 framing, LSB first.
REQ-005 UART_Rx_Data  output  8  last correctly framed byte; registered.
REQ-006 UART_Rx_Data_Ready  output  1  one-clk strobe: UART_Rx_Data has been updated with a new byte.
REQ-007 UART_Rx_Frame_Err  output  1  one-clk strobe: stop bit sampled low.
REQ-008 UART_Rx_Busy  output  1  high in any state other than IDLE.

Function
REQ-009 UART_Rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; the flops reset to 1.
REQ-010 States SHALL be IDLE, START, DATA, STOP and BREAK, with one 16-bit cycle counter (cnt) and one 3-bit bit index (idx).
- HALF = CLKS_PER_BIT/2, using integer division.
REQ-011 IDLE: when rx_s==0 at edge T0, the block SHALL go to START with cnt=0.
REQ-012 Sample points SHALL fall at T0+HALF+k*CLKS_PER_BIT:
- k=0: start bit.
- k=1..8: data bits 0..7.
- k=9: stop bit.
REQ-013 START: at the k=0 sample, rx_s==1 SHALL count as a false start; the block returns to IDLE with no strobe.
- If rx_s==0, the block goes to DATA with idx=0.
REQ-014 DATA: at each sample, rx_s SHALL shift into a shift register MSB-first, so bit 0 ends in position 0.
- idx increments after each sample.
- After idx==7 is sampled, the block goes to STOP.
REQ-015 STOP, rx_s==1 at the k=9 sample:
- UART_Rx_Data <= shift register.
- UART_Rx_Data_Ready =1 for exactly one cycle, the cycle after the sample edge (T0+HALF+9*CLKS_PER_BIT+1).
- Next state IDLE.
REQ-016 STOP, rx_s==0 at the k=9 sample:
- UART_Rx_Frame_Err =1 for one cycle.
- UART_Rx_Data unchanged; no Ready strobe.
- Next state BREAK.
REQ-017 BREAK: the block SHALL stay in BREAK until rx_s==1, then go to IDLE; a continuous low line SHALL NOT produce repeated frames.
REQ-018 Back-to-back frames: a start edge seen in IDLE on the cycle directly after STOP SHALL be accepted; no idle gap beyond the stop bit is needed.
REQ-019 UART_Rx_Data SHALL hold its value between valid frames, including across false starts and framing errors.
REQ-020 UART_Rx_Data_Ready and UART_Rx_Frame_Err SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-021 Line activity during DATA or STOP, other than at sample points, SHALL be ignored; there is no majority voting.

Reset
REQ-022 While rst_n==0, the block SHALL hold these values, regardless of clk:
- state=IDLE, cnt=0, idx=0, shift register=0x00, synchronizer=1.
- UART_Rx_Data=0x00, UART_Rx_Data_Ready=0, UART_Rx_Frame_Err=0, UART_Rx_Busy=0.
REQ-023 A reset asserted mid-frame SHALL discard the partial byte.
- After release, the next falling edge on rx_s is treated as a new start bit.
- This holds even if that edge is a data bit of the interrupted frame.

Verification (CLKS_PER_BIT=16)
REQ-024 Send 0xA5 with a correct stop bit -> UART_Rx_Data=0xA5.
- Ready high exactly 1 cycle, 2+8+144+1 clk after the line falls (±1 for synchronizer phase).
- Frame_Err stays 0.
REQ-025 Send 0x00 then 0xFF with no gap -> two Ready strobes 160 clk apart, carrying 0x00 then 0xFF.
REQ-026 Pulse the line low for 4 clk, then high -> no Ready, no Frame_Err, Busy drops after the half-bit check, UART_Rx_Data unchanged.
REQ-027 Send 0x3C with stop bit=0, line held low for 40 clk, then 0x81 -> Frame_Err strobe once, data stays at its previous value, then Ready with 0x81.
REQ-028 Assert rst_n=0 during bit 4 of a frame, release, then send 0x5A -> all outputs reset and the first Ready carries 0x5A.
- Any Ready or Frame_Err from the interrupted frame's remaining bits is recorded, not failed.
